yuv2rgb_seq: RTL and testbench

- Inverse of the RGB-to-YUV datapath: converts one YUV pixel back to RGB.
- Uses a multi-cycle, resource-shared schedule: one shared multiplier, a coefficient select driven by the FSM, and accumulator registers.
- Sits on the same 9-bit pixel bus as the forward converter, so the two blocks can be chained for round-trip checks.
- Self-contained controller plus datapath with a start/done handshake.

---
 rtl/yuv2rgb_seq.sv | 208 ++++++++++++++++++++
 tb/tb_yuv2rgb_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/yuv2rgb_seq.sv
// Sequential YUV -> RGB converter: one shared multiplier walks four chroma terms
// over MUL0..MUL3, then results are saturated into registered 9-bit outputs.
module yuv2rgb_seq #(
  parameter int BITS    = 9,
  parameter int FRAC    = 6,
  parameter int OFFSET  = 128,
  parameter int COEF_RV = 90,
  parameter int COEF_BU = 113,
  parameter int COEF_GU = 22,
  parameter int COEF_GV = 46
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] inportY,
  input  logic [BITS-1:0] inportU,
  input  logic [BITS-1:0] inportV,
  output logic [BITS-1:0] outportR,
  output logic [BITS-1:0] outportG,
  output logic [BITS-1:0] outportB,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic signed [11:0] OFFSET_S = 12'(OFFSET);
  localparam logic [7:0]         C_RV     = 8'(COEF_RV);
  localparam logic [7:0]         C_BU     = 8'(COEF_BU);
  localparam logic [7:0]         C_GU     = 8'(COEF_GU);
  localparam logic [7:0]         C_GV     = 8'(COEF_GV);
  localparam logic [BITS-1:0]    PIX_MAX  = BITS'(255);

  state_t state_q, state_d;

  logic signed [11:0] y_q, y_d;
  logic signed [11:0] ud_q, ud_d;
  logic signed [11:0] vd_q, vd_d;
  logic signed [11:0] acc_r_q, acc_r_d;
  logic signed [11:0] acc_b_q, acc_b_d;
  logic signed [11:0] acc_g_q, acc_g_d;
  logic [BITS-1:0]    out_r_q, out_r_d;
  logic [BITS-1:0]    out_g_q, out_g_d;
  logic [BITS-1:0]    out_b_q, out_b_d;
  logic               done_q, done_d;

  logic signed [11:0] mul_opnd;
  logic [7:0]         mul_coef;
  logic signed [15:0] prod;
  logic signed [15:0] prod_shift;
  logic signed [11:0] prod_term;
  logic signed [11:0] acc_g_final;
  logic signed [11:0] u_ext;
  logic signed [11:0] v_ext;

  // Bit 8 of the pixel bus and the top bits of the shifted product carry no information.
  logic unused_bits;
  assign unused_bits = ^{inportY[BITS-1:8], inportU[BITS-1:8], inportV[BITS-1:8],
                         prod_shift[15:12]};

  function automatic logic [BITS-1:0] sat(input logic signed [11:0] a);
    logic [BITS-1:0] r;
    if (a < 12'sd0) begin
      r = '0;
    end else if (a > 12'sd255) begin
      r = PIX_MAX;
    end else begin
      r = BITS'(a[7:0]);
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL0;
      MUL0:    state_d = MUL1;
      MUL1:    state_d = MUL2;
      MUL2:    state_d = MUL3;
      MUL3:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode: busy flag and the multiplier operand/coefficient select
  always_comb begin
    busy     = (state_q != IDLE);
    mul_opnd = '0;
    mul_coef = '0;
    case (state_q)
      MUL0: begin
        mul_opnd = vd_q;
        mul_coef = C_RV;
      end
      MUL1: begin
        mul_opnd = ud_q;
        mul_coef = C_BU;
      end
      MUL2: begin
        mul_opnd = ud_q;
        mul_coef = C_GU;
      end
      MUL3: begin
        mul_opnd = vd_q;
        mul_coef = C_GV;
      end
      default: begin
        mul_opnd = '0;
        mul_coef = '0;
      end
    endcase
  end

  // The single shared multiplier; coefficients are positive, so zero-extend them.
  assign prod       = $signed({{4{mul_opnd[11]}}, mul_opnd}) * $signed({8'b0, mul_coef});
  assign prod_shift = prod >>> FRAC;
  assign prod_term  = prod_shift[11:0];

  assign u_ext       = $signed({4'b0, inportU[7:0]});
  assign v_ext       = $signed({4'b0, inportV[7:0]});
  assign acc_g_final = acc_g_q - prod_term;

  // Datapath next-state: capture, accumulate, and final saturating load
  always_comb begin
    y_d     = y_q;
    ud_d    = ud_q;
    vd_d    = vd_q;
    acc_r_d = acc_r_q;
    acc_b_d = acc_b_q;
    acc_g_d = acc_g_q;
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          y_d  = $signed({4'b0, inportY[7:0]});
          ud_d = u_ext - OFFSET_S;
          vd_d = v_ext - OFFSET_S;
        end
      end
      MUL0: acc_r_d = y_q + prod_term;
      MUL1: acc_b_d = y_q + prod_term;
      MUL2: acc_g_d = y_q - prod_term;
      MUL3: begin
        acc_g_d = acc_g_final;
        out_r_d = sat(acc_r_q);
        out_g_d = sat(acc_g_final);
        out_b_d = sat(acc_b_q);
        done_d  = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      ud_q    <= '0;
      vd_q    <= '0;
      acc_r_q <= '0;
      acc_b_q <= '0;
      acc_g_q <= '0;
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      ud_q    <= ud_d;
      vd_q    <= vd_d;
      acc_r_q <= acc_r_d;
      acc_b_q <= acc_b_d;
      acc_g_q <= acc_g_d;
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
      done_q  <= done_d;
    end
  end

  assign outportR = out_r_q;
  assign outportG = out_g_q;
  assign outportB = out_b_q;
  assign done     = done_q;

endmodule

// File: tb/tb_yuv2rgb_seq.sv
// Bench for yuv2rgb_seq: a cycle-level reference model compared every cycle,
// plus directed vectors with hand-computed RGB results and handshake timing.
module tb_yuv2rgb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] in_y = '0;
  logic [8:0] in_u = '0;
  logic [8:0] in_v = '0;
  logic [8:0] out_r, out_g, out_b;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  yuv2rgb_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inportY  (in_y),
    .inportU  (in_u),
    .inportV  (in_v),
    .outportR (out_r),
    .outportG (out_g),
    .outportB (out_b),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by 64 written without shifts.
  function automatic int floor64(input int p);
    if (p >= 0) return p / 64;
    return -((-p + 63) / 64);
  endfunction

  function automatic int clamp(input int a);
    if (a < 0) return 0;
    if (a > 255) return 255;
    return a;
  endfunction

  task automatic model(input int y9, input int u9, input int v9,
                       output int r, output int g, output int b);
    int y, ud, vd;
    y  = y9 % 256;
    ud = (u9 % 256) - 128;
    vd = (v9 % 256) - 128;
    r  = clamp(y + floor64(90 * vd));
    b  = clamp(y + floor64(113 * ud));
    g  = clamp(y - floor64(22 * ud) - floor64(46 * vd));
  endtask

  // Reference model: ph counts cycles since acceptance (0 = idle, 5 = done cycle).
  int ph = 0;
  int m_r = 0, m_g = 0, m_b = 0;
  int p_r = 0, p_g = 0, p_b = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  = 0;
      m_r = 0;
      m_g = 0;
      m_b = 0;
    end else if (ph == 0) begin
      if (start) begin
        model(int'(in_y), int'(in_u), int'(in_v), p_r, p_g, p_b);
        ph = 1;
      end
    end else begin
      if (ph == 4) begin
        m_r = p_r;
        m_g = p_g;
        m_b = p_b;
      end
      ph = (ph == 5) ? 0 : ph + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_R", int'(out_r), m_r);
    check("cyc_G", int'(out_g), m_g);
    check("cyc_B", int'(out_b), m_b);
    check("cyc_busy", int'(busy), (ph != 0) ? 1 : 0);
    check("cyc_done", int'(done), (ph == 5) ? 1 : 0);
  end

  task automatic run(input logic [8:0] y, input logic [8:0] u, input logic [8:0] v,
                     input int er, input int eg, input int eb, input string tag);
    int n;
    @(negedge clk);
    in_y  = y;
    in_u  = u;
    in_v  = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_y  = 9'h0AA;
    in_u  = 9'h155;
    in_v  = 9'h033;
    n = 1;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_R"}, int'(out_r), er);
    check({tag, "_G"}, int'(out_g), eg);
    check({tag, "_B"}, int'(out_b), eb);
    $display("txn %s: Y=%0d U=%0d V=%0d -> R=%0d G=%0d B=%0d latency=%0d",
             tag, y, u, v, out_r, out_g, out_b, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r, g, b, dn;

    // Pin the model against hand-computed values.
    model(255, 255, 255, r, g, b);
    check("model_hi_R", r, 255); check("model_hi_G", g, 121); check("model_hi_B", b, 255);
    model(100, 0, 0, r, g, b);
    check("model_lo_R", r, 0); check("model_lo_G", g, 236); check("model_lo_B", b, 0);
    model(50, 200, 30, r, g, b);
    check("model_mx_R", r, 0); check("model_mx_G", g, 97); check("model_mx_B", b, 177);

    repeat (3) @(negedge clk);
    check("reset_R", int'(out_r), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    run(9'd128, 9'd128, 9'd128, 128, 128, 128, "neutral");
    run(9'd255, 9'd255, 9'd255, 255, 121, 255, "sat_hi");
    run(9'd100, 9'd0,   9'd0,   0,   236, 0,   "sat_lo");
    run(9'd0,   9'd128, 9'd255, 178, 0,   0,   "mixed");
    run(9'h1FF, 9'h180, 9'h180, 255, 255, 255, "bit8");
    run(9'd50,  9'd200, 9'd30,  0,   97,  177, "floor");

    // Start held high: accepted only from IDLE, one result every 6 cycles.
    @(negedge clk);
    in_y  = 9'd0;
    in_u  = 9'd128;
    in_v  = 9'd255;
    start = 1'b1;
    dn = 0;
    repeat (18) begin
      @(negedge clk);
      if (done) dn++;
    end
    start = 1'b0;
    check("hold_done_count", dn, 3);
    check("hold_R", int'(out_r), 178);
    $display("txn hold: start held 18 cycles -> %0d done pulses", dn);

    // Reset in MUL1 discards the conversion.
    @(negedge clk);
    @(negedge clk);
    in_y  = 9'd200;
    in_u  = 9'd50;
    in_v  = 9'd210;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_R", int'(out_r), 0);
    check("midrst_G", int'(out_g), 0);
    check("midrst_B", int'(out_b), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);
    $display("txn midreset: done pulses after reset = %0d", dn);

    run(9'd128, 9'd128, 9'd128, 128, 128, 128, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
